// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the GPR write-port arbiter.
package rf_wb_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_PIPE,
        G_LU
    } grant_e;

    // One-hot scoreboard mask for a register number.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering late long-unit results until they win the port.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t wdata_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single GPR write port between pipeline writeback and late long-unit
// results, with a busy scoreboard for hazards and a bounded wait for the late unit.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_valid,
    input  logic [REG_W-1:0]    p_addr,
    input  logic [DATA_W-1:0]   p_data,
    output logic                p_stall,
    input  logic                iss_valid,
    input  logic [REG_W-1:0]    iss_addr,
    output logic                iss_ready,
    input  logic                lu_valid,
    input  logic [REG_W-1:0]    lu_addr,
    input  logic [DATA_W-1:0]   lu_data,
    output logic                lu_ready,
    output logic                rf_wen,
    output logic [REG_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ST_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    wb_entry_t           head;
    wb_entry_t           lu_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                iss_accept;
    logic                force_lu;
    logic                p_block;
    grant_e              grant;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic [ST_W-1:0]     starve_q, starve_d;

    assign lu_entry = '{addr: lu_addr, data: lu_data};

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (lu_entry),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // Grant: starved FIFO head first, then an unblocked pipeline write, then the FIFO.
    always_comb begin
        force_lu = !fifo_empty && (starve_q == ST_W'(MAX_WAIT));
        p_block  = p_valid && (p_addr != '0) && busy_q[p_addr];
        grant    = G_NONE;
        if (!rst) begin
            if (force_lu) begin
                grant = G_LU;
            end else if (p_valid && !p_block) begin
                grant = G_PIPE;
            end else if (!fifo_empty) begin
                grant = G_LU;
            end
        end
    end

    // Write port is driven straight from the grant; r0 writes are consumed silently.
    always_comb begin
        rf_waddr = p_addr;
        rf_wdata = p_data;
        if (grant == G_LU) begin
            rf_waddr = head.addr;
            rf_wdata = head.data;
        end
        rf_wen    = (grant != G_NONE) && (rf_waddr != '0);
        p_stall   = !rst && p_valid && (grant != G_PIPE);
        lu_ready  = !rst && !fifo_full;
        iss_ready = !rst && ((iss_addr == '0) || !busy_q[iss_addr])
                    && (outst_q < CNT_W'(DEPTH));
    end

    assign busy       = busy_q;
    assign pop        = (grant == G_LU);
    assign push       = lu_valid && lu_ready;
    assign iss_accept = iss_valid && iss_ready;

    always_comb begin
        busy_d   = busy_q;
        outst_d  = outst_q;
        starve_d = starve_q;

        if (pop) begin
            busy_d = busy_d & ~reg_onehot(head.addr);
        end
        if (iss_accept) begin
            busy_d = busy_d | reg_onehot(iss_addr);
        end
        busy_d[0] = 1'b0;

        case ({iss_accept, pop})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        // Counts cycles the head has been denied the port, saturating at the limit.
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != ST_W'(MAX_WAIT)) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            outst_q  <= '0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            outst_q  <= outst_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then a
// randomized run, both checked every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        p_stall;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .p_stall   (p_stall),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .lu_valid  (lu_valid),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    // Reference model state: buffered results, scoreboard, in-flight long ops.
    bit [4:0]  mq_a[$];
    bit [31:0] mq_d[$];
    bit [4:0]  pend[$];
    bit [31:0] m_busy;
    int        m_out;
    int        m_wait;
    bit        last_stall;
    int        checks;
    int        errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        p_valid   = 1'b0;
        p_addr    = 5'd0;
        p_data    = 32'd0;
        iss_valid = 1'b0;
        iss_addr  = 5'd0;
        lu_valid  = 1'b0;
        lu_addr   = 5'd0;
        lu_data   = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check this cycle's outputs against the model, then advance the model.
    task automatic step();
        int       n;
        int       g;
        bit       frc;
        bit       pblk;
        bit       popped;
        bit       e_wen;
        bit       e_stall;
        bit       e_iss;
        bit       e_lur;
        bit [4:0] wa;
        bit [31:0] wd;
        @(negedge clk);
        n       = mq_a.size();
        g       = 0;
        e_wen   = 1'b0;
        e_stall = 1'b0;
        e_iss   = 1'b0;
        e_lur   = 1'b0;
        wa      = p_addr;
        wd      = p_data;
        if (!rst) begin
            e_lur = (n < int'(DEPTH));
            e_iss = ((iss_addr == 5'd0) || !m_busy[iss_addr]) && (m_out < int'(DEPTH));
            frc   = (n > 0) && (m_wait == int'(MAX_WAIT));
            pblk  = p_valid && (p_addr != 5'd0) && m_busy[p_addr];
            if (frc) g = 2;
            else if (p_valid && !pblk) g = 1;
            else if (n > 0) g = 2;
            if (g == 2) begin
                wa = mq_a[0];
                wd = mq_d[0];
            end
            e_wen   = (g != 0) && (wa != 5'd0);
            e_stall = p_valid && (g != 1);
        end

        chk("rf_wen", 32'(rf_wen), 32'(e_wen));
        chk("p_stall", 32'(p_stall), 32'(e_stall));
        chk("iss_ready", 32'(iss_ready), 32'(e_iss));
        chk("lu_ready", 32'(lu_ready), 32'(e_lur));
        chk("busy", busy, m_busy);
        if (e_wen) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(wa));
            chk("rf_wdata", rf_wdata, wd);
        end
        last_stall = e_stall;

        if (rst) begin
            mq_a.delete();
            mq_d.delete();
            pend.delete();
            m_busy = '0;
            m_out  = 0;
            m_wait = 0;
        end else begin
            popped = (g == 2);
            if (lu_valid && e_lur) begin
                checks++;
                if ((lu_addr != 5'd0) && !m_busy[lu_addr]) begin
                    errors++;
                    $display("FAIL lu_protocol actual=r%0d required=busy_reg", lu_addr);
                end
            end
            if (popped) begin
                if (mq_a[0] != 5'd0) m_busy[mq_a[0]] = 1'b0;
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
                m_out--;
            end
            if (iss_valid && e_iss) begin
                m_out++;
                if (iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
                pend.push_back(iss_addr);
            end
            if (lu_valid && e_lur) begin
                mq_a.push_back(lu_addr);
                mq_d.push_back(lu_data);
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i] == lu_addr) begin
                        pend.delete(i);
                        break;
                    end
                end
            end
            if ((n == 0) || popped) m_wait = 0;
            else if (m_wait < int'(MAX_WAIT)) m_wait = m_wait + 1;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_busy     = '0;
        m_out      = 0;
        m_wait     = 0;
        last_stall = 1'b0;
        idle();
        rst = 1'b1;

        step();
        chk("rst_wen", 32'(rf_wen), 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd0);
        chk("rst_busy", busy, 32'd0);
        tick();
        step();
        tick();
        rst = 1'b0;

        // Idle port goes straight to the pipeline in the same cycle.
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234;
        step();
        chk("t1_wen", 32'(rf_wen), 32'd1);
        chk("t1_waddr", 32'(rf_waddr), 32'd5);
        chk("t1_wdata", rf_wdata, 32'h1234);
        chk("t1_stall", 32'(p_stall), 32'd0);
        tick();

        // Issue r8, return its result, no same-cycle bypass.
        idle();
        iss_valid = 1'b1; iss_addr = 5'd8;
        step(); chk("t2_iss_ready", 32'(iss_ready), 32'd1); tick();
        idle();
        lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'hABCD;
        step();
        chk("t2_busy8", 32'(busy[8]), 32'd1);
        chk("t2_no_bypass", 32'(rf_wen), 32'd0);
        tick();
        idle();
        step();
        chk("t2_wen", 32'(rf_wen), 32'd1);
        chk("t2_waddr", 32'(rf_waddr), 32'd8);
        chk("t2_wdata", rf_wdata, 32'hABCD);
        tick();
        step(); chk("t2_busy8_clr", 32'(busy[8]), 32'd0); tick();

        // WAW guard on r9.
        iss_valid = 1'b1; iss_addr = 5'd9;
        step(); tick();
        idle();
        p_valid = 1'b1; p_addr = 5'd9; p_data = 32'h99;
        step();
        chk("t3_stall_a", 32'(p_stall), 32'd1);
        chk("t3_wen_a", 32'(rf_wen), 32'd0);
        tick();
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h777;
        step(); chk("t3_stall_b", 32'(p_stall), 32'd1); tick();
        lu_valid = 1'b0;
        step();
        chk("t3_stall_c", 32'(p_stall), 32'd1);
        chk("t3_lu_waddr", 32'(rf_waddr), 32'd9);
        chk("t3_lu_wdata", rf_wdata, 32'h777);
        tick();
        step();
        chk("t3_pipe_stall", 32'(p_stall), 32'd0);
        chk("t3_pipe_wdata", rf_wdata, 32'h99);
        tick();

        // Starvation: head denied four cycles, forced on the fifth.
        idle();
        iss_valid = 1'b1; iss_addr = 5'd10;
        step(); tick();
        idle();
        for (int k = 0; k <= 6; k++) begin
            lu_valid = (k == 0);
            lu_addr  = 5'd10;
            lu_data  = 32'hA10;
            p_valid  = 1'b1;
            p_addr   = (k == 0) ? 5'd7 : ((k <= 5) ? 5'(k) : 5'd5);
            p_data   = 32'h100 + 32'(p_addr);
            step();
            if (k == 5) begin
                chk("t4_forced_stall", 32'(p_stall), 32'd1);
                chk("t4_forced_waddr", 32'(rf_waddr), 32'd10);
            end else begin
                chk("t4_pipe_stall", 32'(p_stall), 32'd0);
                chk("t4_pipe_waddr", 32'(rf_waddr), 32'(p_addr));
            end
            tick();
        end

        // Outstanding limit and FIFO full.
        idle();
        p_valid = 1'b1; p_addr = 5'd1; p_data = 32'h5001;
        iss_valid = 1'b1; iss_addr = 5'd11;
        step(); chk("t5_iss11", 32'(iss_ready), 32'd1); tick();
        iss_addr = 5'd12;
        step(); chk("t5_iss12", 32'(iss_ready), 32'd1); tick();
        iss_addr = 5'd13; lu_valid = 1'b1; lu_addr = 5'd11; lu_data = 32'hB11;
        step(); chk("t5_iss_limit", 32'(iss_ready), 32'd0); tick();
        iss_valid = 1'b0; lu_addr = 5'd12; lu_data = 32'hB12;
        step(); chk("t5_lu_ready_one", 32'(lu_ready), 32'd1); tick();
        lu_valid = 1'b0;
        step(); chk("t5_lu_full", 32'(lu_ready), 32'd0); tick();
        p_valid = 1'b0;
        step();
        chk("t5_pop_waddr", 32'(rf_waddr), 32'd11);
        chk("t5_pop_wdata", rf_wdata, 32'hB11);
        tick();
        step();
        chk("t5_lu_ready_back", 32'(lu_ready), 32'd1);
        chk("t5_pop2_waddr", 32'(rf_waddr), 32'd12);
        tick();
        step(); chk("t5_busy_clear", busy, 32'd0); tick();

        // r0 issue/result, then reset with a full FIFO.
        idle();
        iss_valid = 1'b1; iss_addr = 5'd0;
        step(); chk("t6_iss_r0", 32'(iss_ready), 32'd1); tick();
        idle();
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hDEAD;
        step(); chk("t6_busy_r0", busy, 32'd0); tick();
        lu_valid = 1'b0;
        step();
        chk("t6_r0_wen", 32'(rf_wen), 32'd0);
        chk("t6_r0_stall", 32'(p_stall), 32'd0);
        tick();
        p_valid = 1'b1; p_addr = 5'd1; p_data = 32'h6001;
        iss_valid = 1'b1; iss_addr = 5'd14;
        step(); tick();
        iss_addr = 5'd15;
        step(); tick();
        iss_valid = 1'b0; lu_valid = 1'b1; lu_addr = 5'd14; lu_data = 32'hE14;
        step(); tick();
        lu_addr = 5'd15; lu_data = 32'hE15;
        step(); tick();
        lu_valid = 1'b0;
        step(); chk("t6_full", 32'(lu_ready), 32'd0); tick();
        rst = 1'b1;
        step();
        chk("t6_rst_wen", 32'(rf_wen), 32'd0);
        chk("t6_rst_iss", 32'(iss_ready), 32'd0);
        chk("t6_rst_lu", 32'(lu_ready), 32'd0);
        chk("t6_rst_stall", 32'(p_stall), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        iss_addr = 5'd14;
        step();
        chk("t6_post_busy", busy, 32'd0);
        chk("t6_post_iss", 32'(iss_ready), 32'd1);
        chk("t6_post_lu", 32'(lu_ready), 32'd1);
        chk("t6_post_wen", 32'(rf_wen), 32'd0);
        tick();

        // Randomized traffic honouring the issue and hold protocols.
        for (int c = 0; c < 4000; c++) begin
            int idx;
            rst = ($urandom_range(0, 399) == 0);
            if (!last_stall || rst) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_addr  = 5'($urandom_range(0, 15));
                p_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr  = 5'($urandom_range(0, 15));
            if ((pend.size() > 0) && ($urandom_range(0, 1) == 1)) begin
                idx      = int'($urandom_range(0, pend.size() - 1));
                lu_valid = 1'b1;
                lu_addr  = pend[idx];
            end else begin
                lu_valid = 1'b0;
                lu_addr  = 5'($urandom_range(0, 31));
            end
            lu_data = $urandom;
            step();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single GPR-file write port (wen / r3 / WD) of the MIPS-lite core.
- Shares that port between two sources:
  - the in-order pipeline writeback;
  - a multi-cycle execution unit (mult/div) that returns results late.
- Buffers late results and keeps a 32-bit busy scoreboard for hazard stalls.
- Bounds starvation of the late unit.

Parameters:
- DEPTH, 2: late-result FIFO entries; also the maximum number of outstanding long ops.
- MAX_WAIT, 4: cycles a buffered result may be denied the port before it takes priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- p_valid  in  1  pipeline writeback request
- p_addr  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- p_stall  out  1  pipeline writeback not accepted this cycle; hold p_* stable
- iss_valid  in  1  long op issuing, with destination iss_addr
- iss_addr  in  5  long-op destination register
- iss_ready  out  1  issue accepted
- lu_valid  in  1  long-unit result valid
- lu_addr  in  5  long-unit result destination
- lu_data  in  32  long-unit result data
- lu_ready  out  1  FIFO can accept a result
- rf_wen  out  1  to regfile wen
- rf_waddr  out  5  to regfile r3
- rf_wdata  out  32  to regfile WD
- busy  out  32  scoreboard, one bit per GPR; bit 0 is always 0

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, busy=0, outstanding=0, starve_cnt=0.
  - While rst is high, rf_wen, p_stall, iss_ready and lu_ready are forced to 0.
- FIFO and push:
  - DEPTH entries of {addr, data}; lu_ready = !full.
  - Push on lu_valid && lu_ready.
  - A result pushed in cycle N is writable no earlier than cycle N+1; there is no same-cycle bypass to the port.
- Arbitration and write port:
  - All write-port outputs are combinational from the grant; the regfile commits at the end of the same cycle.
  - force = !empty && (starve_cnt == MAX_WAIT).
  - p_block = p_valid && p_addr!=0 && busy[p_addr], a WAW guard.
  - Grant order:
    1. If force: grant FIFO head.
    2. Else if p_valid && !p_block: grant pipeline.
    3. Else if !empty: grant FIFO head.
    4. Else: no grant.
  - p_stall = p_valid && !(pipeline granted).
- Write-port drive:
  - rf_wen=1 whenever a grant exists and the granted addr != 0.
  - Writes to r0 are granted, popped and cleared, but rf_wen stays 0.
  - rf_waddr/rf_wdata come from the granted source; they are don't-care when rf_wen=0.
- Pop: the FIFO head is popped when the FIFO is granted.
- starve_cnt:
  - Cleared on pop, and held at 0 while empty.
  - Otherwise increments while !empty and no pop, saturating at MAX_WAIT.
- Issue and scoreboard:
  - iss_ready = !busy[iss_addr] && outstanding < DEPTH (iss_addr=0 needs only the count check).
  - On accept: outstanding+1, and busy[iss_addr] is set when iss_addr != 0.
  - On FIFO pop: outstanding-1, and busy[head.addr] is cleared.
  - Accept and pop in the same cycle: outstanding is unchanged. Set and clear of different bits both apply.
  - Set and clear of the same bit cannot occur, because iss_ready=0 while the bit is busy.
- Invariants:
  - outstanding ≤ DEPTH, so the FIFO never overflows when the unit honours the issue protocol.
  - An lu result to a register not busy (and not r0) is a protocol violation; the bench flags it and RTL behaviour is unspecified.
- Reset mid-operation:
  - Buffered results and busy bits are discarded.
  - The pipeline and long unit are flushed by the same rst.

Decomposition:
- Package rf_wb_pkg:
  - REG_W=5 and DATA_W=32 constants;
  - typedef wb_entry_t {addr, data};
  - grant enum {G_NONE, G_PIPE, G_LU}.
- One sub-module: rf_wb_fifo (DEPTH-entry synchronous FIFO).
  - Ports: push, pop, full, empty, head.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
- Arbitration, scoreboard and starvation counter stay in the top.

Test Plan:
1. Reset then idle: after rst, p_valid=1, p_addr=5, p_data=0x1234 → same cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, p_stall=0.
2. Issue and return:
   - Issue iss_addr=8 → busy[8]=1 next cycle.
   - lu result {8, 0xABCD} pushed at cycle N with p_valid=0 → rf_wen at N+1 with addr 8; busy[8]=0 after N+1.
3. WAW guard: busy[8]=1 and p_valid with p_addr=8 → p_stall=1, rf_wen=0 until the FIFO writes r8; the pipeline write follows in the next cycle.
4. Starvation:
   - One buffered result with p_valid=1 to non-busy regs every cycle.
   - The FIFO is denied for 4 cycles, then forced on the 5th cycle: p_stall=1 and rf_waddr = FIFO addr; starve_cnt then returns to 0.
5. Full and limits:
   - Two outstanding issues → iss_ready=0 for a third distinct addr.
   - Two results buffered while the pipeline hogs the port → lu_ready=0; after one pop, lu_ready=1.
6. r0 and reset:
   - Issue to r0 leaves busy=0.
   - Its result pops with rf_wen=0.
   - rst asserted with 2 entries buffered → next cycle empty, busy=0, iss_ready=1.
